// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and address-width helper
// shared by every FIFO in the design.
package fifo_pkg;

  localparam int FIFO_SHOWAHEAD = 1;
  localparam int FIFO_NORMAL    = 0;

  function automatic int fifo_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port array, synchronous write,
// asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WORD   = 16,
  parameter int LENGTH = 128,
  localparam int AW    = fifo_aw(LENGTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [WORD-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [WORD-1:0] rdata
);

  logic [WORD-1:0] mem [LENGTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sc.sv
// fifo_sc: single-clock FIFO, show-ahead or registered read.
// Sticky overflow/underflow flags built only with FIFO_ERR_FLAGS_EN.
module fifo_sc
  import fifo_pkg::*;
#(
  parameter int WORD      = 16,
  parameter int LENGTH    = 128,
  parameter int ALMOST_E  = 2,
  parameter int ALMOST_F  = 126,
  parameter int SHOWAHEAD = 1,
  localparam int AW       = fifo_aw(LENGTH),
  localparam int CW       = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sclr,
  input  logic [WORD-1:0] data,
  input  logic            wrreq,
  input  logic            rdreq,
  output logic [WORD-1:0] q,
  output logic [CW-1:0]   usedw,
  output logic            empty,
  output logic            full,
  output logic            almost_empty,
  output logic            almost_full,
  output logic            overflow,
  output logic            underflow
);

  localparam logic [CW-1:0] FULL_C = CW'(LENGTH);
  localparam logic [CW-1:0] AE_C   = CW'(ALMOST_E);
  localparam logic [CW-1:0] AF_C   = CW'(ALMOST_F);

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            wr_acc;
  logic            rd_acc;
  logic            ram_we;
  logic [WORD-1:0] rdata;

  assign empty        = (count == '0);
  assign full         = (count == FULL_C);
  assign almost_empty = (count < AE_C);
  assign almost_full  = (count >= AF_C);
  assign usedw        = count;

  assign wr_acc = wrreq & ~full;
  assign rd_acc = rdreq & ~empty;
  // sclr wins, so a write in the same cycle must not reach memory
  assign ram_we = wr_acc & ~sclr;

  fifo_ram #(
    .WORD   (WORD),
    .LENGTH (LENGTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (wr_acc & ~rd_acc): count <= count + CW'(1);
        (rd_acc & ~wr_acc): count <= count - CW'(1);
        default:            count <= count;
      endcase
    end
  end

  generate
    if (SHOWAHEAD == FIFO_SHOWAHEAD) begin : g_sa
      assign q = rdata;
    end else begin : g_nm
      logic [WORD-1:0] q_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q_r <= '0;
        else if (sclr)   q_r <= '0;
        else if (rd_acc) q_r <= rdata;
      end
      assign q = q_r;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_r;
  logic unf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (sclr) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      if (wrreq & full)  ovf_r <= 1'b1;
      if (rdreq & empty) unf_r <= 1'b1;
    end
  end

  assign overflow  = ovf_r;
  assign underflow = unf_r;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sc.sv
// tb_fifo_sc: scoreboard bench driving a show-ahead and a
// normal-mode fifo_sc with identical stimulus.
module tb_fifo_sc;

  localparam int LEN = 8;
  localparam int CW  = 4;
`ifdef FIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sclr;
  logic [7:0]    data;
  logic          wrreq;
  logic          rdreq;

  logic [7:0]    q_sa, q_nm;
  logic [CW-1:0] uw_sa, uw_nm;
  logic          em_sa, em_nm, fu_sa, fu_nm;
  logic          ae_sa, ae_nm, af_sa, af_nm;
  logic          ov_sa, ov_nm, un_sa, un_nm;

  fifo_sc #(
    .WORD(8), .LENGTH(LEN), .ALMOST_E(2),
    .ALMOST_F(6), .SHOWAHEAD(1)
  ) u_sa (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_sa), .usedw(uw_sa), .empty(em_sa),
    .full(fu_sa), .almost_empty(ae_sa),
    .almost_full(af_sa), .overflow(ov_sa),
    .underflow(un_sa)
  );

  fifo_sc #(
    .WORD(8), .LENGTH(LEN), .ALMOST_E(2),
    .ALMOST_F(6), .SHOWAHEAD(0)
  ) u_nm (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q_nm), .usedw(uw_nm), .empty(em_nm),
    .full(fu_nm), .almost_empty(ae_nm),
    .almost_full(af_nm), .overflow(ov_nm),
    .underflow(un_nm)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  int         mcnt = 0;
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;

  task automatic model_clear();
    sb.delete();
    mcnt = 0;
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // one clock of stimulus; called just after a falling edge
  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r, output logic pop,
                     output logic [7:0] exp,
                     output logic [7:0] qsa,
                     output logic [7:0] qnm);
    logic wacc;
    wrreq = w;
    data  = d;
    rdreq = r;
    sclr  = 1'b0;
    wacc  = w && (mcnt < LEN);
    pop   = r && (mcnt > 0);
    if (w && mcnt == LEN) m_ov = ERR;
    if (r && mcnt == 0)   m_un = ERR;
    exp = 8'h00;
    if (pop) exp = sb.pop_front();
    qsa = q_sa;
    @(posedge clk);
    #1;
    qnm = q_nm;
    if (wacc) sb.push_back(d);
    mcnt = mcnt + (wacc ? 1 : 0) - (pop ? 1 : 0);
    @(negedge clk);
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclr  = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = 8'h00;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp += 8;
    if (uw_sa !== 4'd0 || uw_nm !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_usedw got %0d/%0d want 0", uw_sa, uw_nm);
    end
    if (em_sa !== 1'b1 || em_nm !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_empty got %b/%b want 1", em_sa, em_nm);
    end
    if (ae_sa !== 1'b1 || ae_nm !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_aempty got %b/%b want 1", ae_sa, ae_nm);
    end
    if (fu_sa !== 1'b0 || fu_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_full got %b/%b want 0", fu_sa, fu_nm);
    end
    if (af_sa !== 1'b0 || af_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_afull got %b/%b want 0", af_sa, af_nm);
    end
    if (q_nm !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_q got %h want 00", q_nm);
    end
    if (ov_sa !== 1'b0 || ov_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ovf got %b/%b want 0", ov_sa, ov_nm);
    end
    if (un_sa !== 1'b0 || un_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_unf got %b/%b want 0", un_sa, un_nm);
    end
  endtask

  task automatic test_fill();
    logic       pop;
    logic [7:0] exp, qa, qn;
    for (int i = 0; i < LEN; i++) begin
      cyc(1'b1, 8'h11 + 8'(i), 1'b0, pop, exp, qa, qn);
      n_cmp += 4;
      if (uw_sa !== CW'(mcnt) || uw_nm !== CW'(mcnt)) begin
        n_bad++;
        $display("FAIL fill_usedw got %0d/%0d want %0d",
                 uw_sa, uw_nm, mcnt);
      end
      if (af_sa !== (mcnt >= 6) || af_nm !== (mcnt >= 6)) begin
        n_bad++;
        $display("FAIL fill_afull at %0d got %b/%b", mcnt, af_sa, af_nm);
      end
      if (fu_sa !== (mcnt == LEN) || fu_nm !== (mcnt == LEN)) begin
        n_bad++;
        $display("FAIL fill_full at %0d got %b/%b", mcnt, fu_sa, fu_nm);
      end
      if (ae_sa !== (mcnt < 2) || em_sa !== 1'b0) begin
        n_bad++;
        $display("FAIL fill_aempty at %0d got ae=%b em=%b",
                 mcnt, ae_sa, em_sa);
      end
    end
    cyc(1'b1, 8'h19, 1'b0, pop, exp, qa, qn);
    n_cmp += 2;
    if (uw_sa !== 4'd8 || uw_nm !== 4'd8) begin
      n_bad++;
      $display("FAIL ovf_usedw got %0d/%0d want 8", uw_sa, uw_nm);
    end
    if (ov_sa !== m_ov || ov_nm !== m_ov) begin
      n_bad++;
      $display("FAIL ovf_flag got %b/%b want %b", ov_sa, ov_nm, m_ov);
    end
  endtask

  task automatic test_full_rw();
    logic       pop;
    logic [7:0] exp, qa, qn;
    cyc(1'b1, 8'h19, 1'b1, pop, exp, qa, qn);
    n_cmp += 3;
    if (!pop || qa !== exp || qa !== 8'h11) begin
      n_bad++;
      $display("FAIL fullrw_q_sa got %h want %h", qa, exp);
    end
    if (qn !== exp) begin
      n_bad++;
      $display("FAIL fullrw_q_nm got %h want %h", qn, exp);
    end
    if (uw_sa !== 4'd7 || uw_nm !== 4'd7) begin
      n_bad++;
      $display("FAIL fullrw_usedw got %0d/%0d want 7", uw_sa, uw_nm);
    end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 8'h00, 1'b1, pop, exp, qa, qn);
      n_cmp += 2;
      if (qa !== exp) begin
        n_bad++;
        $display("FAIL drain_q_sa got %h want %h", qa, exp);
      end
      if (qn !== exp) begin
        n_bad++;
        $display("FAIL drain_q_nm got %h want %h", qn, exp);
      end
    end
    n_cmp += 1;
    if (em_sa !== 1'b1 || em_nm !== 1'b1 || uw_sa !== 4'd0) begin
      n_bad++;
      $display("FAIL drain_empty got %b/%b usedw %0d want 1/1/0",
               em_sa, em_nm, uw_sa);
    end
  endtask

  task automatic test_empty_rw();
    logic       pop;
    logic [7:0] exp, qa, qn;
    cyc(1'b1, 8'hAB, 1'b1, pop, exp, qa, qn);
    n_cmp += 3;
    if (un_sa !== m_un || un_nm !== m_un) begin
      n_bad++;
      $display("FAIL unf_flag got %b/%b want %b", un_sa, un_nm, m_un);
    end
    if (uw_sa !== 4'd1 || uw_nm !== 4'd1) begin
      n_bad++;
      $display("FAIL emptyrw_usedw got %0d/%0d want 1", uw_sa, uw_nm);
    end
    if (q_sa !== 8'hAB) begin
      n_bad++;
      $display("FAIL emptyrw_q_sa got %h want ab", q_sa);
    end
  endtask

  task automatic test_back_to_back();
    logic       pop;
    logic [7:0] exp, qa, qn;
    for (int i = 0; i < 3 * LEN; i++) begin
      cyc(1'b1, 8'($urandom_range(0, 255)), 1'b1, pop, exp, qa, qn);
      n_cmp += 3;
      if (qa !== exp) begin
        n_bad++;
        $display("FAIL b2b_q_sa cycle %0d got %h want %h", i, qa, exp);
      end
      if (qn !== exp) begin
        n_bad++;
        $display("FAIL b2b_q_nm cycle %0d got %h want %h", i, qn, exp);
      end
      if (uw_sa !== 4'd1 || uw_nm !== 4'd1) begin
        n_bad++;
        $display("FAIL b2b_usedw got %0d/%0d want 1", uw_sa, uw_nm);
      end
    end
  endtask

  task automatic test_async_reset();
    logic       pop;
    logic [7:0] exp, qa, qn;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'h30 + 8'(i), 1'b0, pop, exp, qa, qn);
    n_cmp += 1;
    if (uw_sa !== 4'd5) begin
      n_bad++;
      $display("FAIL arst_pre_usedw got %0d want 5", uw_sa);
    end
    wrreq = 1'b1;
    data  = 8'h77;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp += 4;
    if (uw_sa !== 4'd0 || uw_nm !== 4'd0) begin
      n_bad++;
      $display("FAIL arst_usedw got %0d/%0d want 0", uw_sa, uw_nm);
    end
    if (em_sa !== 1'b1 || ae_nm !== 1'b1 || fu_sa !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_flags got em=%b ae=%b fu=%b", em_sa, ae_nm, fu_sa);
    end
    if (q_nm !== 8'h00) begin
      n_bad++;
      $display("FAIL arst_q got %h want 00", q_nm);
    end
    if (ov_sa !== 1'b0 || un_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_err got %b/%b want 0", ov_sa, un_nm);
    end
    wrreq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sclr();
    logic       pop;
    logic [7:0] exp, qa, qn;
    cyc(1'b0, 8'h00, 1'b1, pop, exp, qa, qn);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'h40 + 8'(i), 1'b0, pop, exp, qa, qn);
    cyc(1'b0, 8'h00, 1'b1, pop, exp, qa, qn);
    cyc(1'b1, 8'h45, 1'b0, pop, exp, qa, qn);
    n_cmp += 2;
    if (uw_nm !== 4'd5 || q_nm !== 8'h40) begin
      n_bad++;
      $display("FAIL sclr_pre got usedw %0d q %h want 5/40", uw_nm, q_nm);
    end
    if (un_sa !== m_un) begin
      n_bad++;
      $display("FAIL sclr_pre_unf got %b want %b", un_sa, m_un);
    end
    sclr  = 1'b1;
    wrreq = 1'b1;
    data  = 8'h55;
    @(posedge clk);
    #1;
    model_clear();
    n_cmp += 3;
    if (uw_sa !== 4'd0 || uw_nm !== 4'd0 || em_sa !== 1'b1) begin
      n_bad++;
      $display("FAIL sclr_usedw got %0d/%0d em %b want 0/0/1",
               uw_sa, uw_nm, em_sa);
    end
    if (q_nm !== 8'h00) begin
      n_bad++;
      $display("FAIL sclr_q got %h want 00", q_nm);
    end
    if (un_sa !== 1'b0 || un_nm !== 1'b0) begin
      n_bad++;
      $display("FAIL sclr_unf got %b/%b want 0", un_sa, un_nm);
    end
    @(negedge clk);
    sclr  = 1'b0;
    wrreq = 1'b0;
    cyc(1'b1, 8'h66, 1'b0, pop, exp, qa, qn);
    cyc(1'b0, 8'h00, 1'b1, pop, exp, qa, qn);
    n_cmp += 1;
    if (!pop || qa !== 8'h66 || qn !== 8'h66) begin
      n_bad++;
      $display("FAIL sclr_after got %h/%h want 66", qa, qn);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_async_reset();
    test_sclr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_sc.md
# fifo_sc

Parametrised single-clock FIFO: the next generation of our synchronous buffer between processor I/O ports and peripheral cores. It adds an occupancy counter that uses every slot, independent almost-full and almost-empty thresholds, and a selectable show-ahead or normal read mode. It also has an asynchronous active-low reset and optional sticky overflow/underflow flags. It drops in wherever a processor output stream crosses into a slower consumer, or a sampled input waits for a processor `IN`.

## Interface
Parameters:
- `WORD`, 16: data width in bits, ≥1.
- `LENGTH`, 128: depth in words, power of two, ≥2.
- `ALMOST_E`, 2: `almost_empty` asserted while occupancy < `ALMOST_E`.
- `ALMOST_F`, 126: `almost_full` asserted while occupancy ≥ `ALMOST_F`.
- `SHOWAHEAD`, 1: 1 = first-word fall-through, 0 = registered read.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclr`  in  1  synchronous clear.
- `data`  in  `WORD`  write data.
- `wrreq`  in  1  write request.
- `rdreq`  in  1  read request.
- `q`  out  `WORD`  read data.
- `usedw`  out  `$clog2(LENGTH)+1`  occupancy, 0..`LENGTH`.
- `empty`  out  1  occupancy == 0.
- `full`  out  1  occupancy == `LENGTH`.
- `almost_empty`  out  1  threshold flag.
- `almost_full`  out  1  threshold flag.
- `overflow`  out  1  sticky: write attempted while full.
- `underflow`  out  1  sticky: read attempted while empty.

## Operation
- State: `wr_ptr` and `rd_ptr` (each `$clog2(LENGTH)` bits, wrap naturally), and `count` (`$clog2(LENGTH)+1` bits).
- A write is accepted iff `wrreq & ~full`: `mem[wr_ptr] <= data`, then `wr_ptr` increments.
- A read is accepted iff `rdreq & ~empty`: `rd_ptr` increments.
- Count update:
  - write only: `count` +1;
  - read only: `count` −1;
  - both accepted: `count` unchanged, both pointers advance.
- Full with `wrreq & rdreq`: the read is accepted and the write is rejected. Acceptance is evaluated on current flags only.
- Empty with `wrreq & rdreq`: the write is accepted and the read is rejected. There is no bypass.
- All flags are decoded combinationally from the `count` register only, so they are independent of request inputs. `usedw = count`.
- `SHOWAHEAD=1`: `q = mem[rd_ptr]` combinationally. It is valid whenever `~empty`; its value is don't-care when empty.
- `SHOWAHEAD=0`: `q` is a register loaded with `mem[rd_ptr]` on an accepted read and holds otherwise.
- `sclr` has priority over write and read. It zeroes the pointers, `count`, the error flags and, in normal mode, `q`. Memory contents are untouched.
- Reset (`rst_n=0`, any time, including mid-burst) gives the same result as `sclr`, applied asynchronously.
- Reset values: `usedw=0`, `empty=1`, `full=0`, `almost_empty=1` (for `ALMOST_E`≥1), `almost_full=0`, `q=0` (normal mode), `overflow=0`, `underflow=0`.

## Timing
- Write at edge N: `empty` falls and `usedw` updates after edge N. In show-ahead mode the word appears on `q` in cycle N+1.
- Normal mode: `rdreq` sampled at edge N; `q` holds the word after edge N (1-cycle read latency).
- Sustained throughput: one write and one read per cycle.
- Flags change only on clock edges, or on the asynchronous `rst_n` assertion.
- `rst_n` deassertion is synchronised externally. The first active edge follows deassertion.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on `wrreq & full & ~sclr`;
  - `underflow` sets on `rdreq & empty & ~sclr`;
  - both hold until `sclr` or `rst_n`.
- Not defined: `overflow` and `underflow` are tied to 0, and the detection logic and registers are absent. The port list is identical in both builds.

## Structure
- Shared package `fifo_pkg` holds:
  - `FIFO_SHOWAHEAD=1` and `FIFO_NORMAL=0` mode constants;
  - an address-width function wrapping `$clog2`, used by every FIFO in the design.
- Sub-module `fifo_ram`: simple dual-port array with synchronous write and asynchronous read, parametrised by `WORD` and `LENGTH`. Pointer, count, flag and output-register logic stay in `fifo_sc`.

## Test plan
- Reset then idle: `usedw=0`, `empty=1`, `almost_empty=1`, `full=0`, `q=0` (normal mode).
- `LENGTH=8`, `ALMOST_F=6`: write 0x11..0x18 on consecutive cycles.
  - `almost_full` rises when `usedw` reaches 6, `full` when it reaches 8.
  - A ninth write of 0x19 is rejected, `usedw` stays 8, and `overflow=1` with the macro defined.
- Full FIFO, `wrreq=rdreq=1` for one cycle: 0x11 is read out, 0x19 is not stored, `usedw=7`.
  - Drain the FIFO: output sequence 0x12..0x18, then `empty=1`.
- Empty FIFO, simultaneous write 0xAB and read: `underflow=1` with the macro defined, `usedw=1`.
  - Show-ahead mode: `q=0xAB` on the next cycle.
- Sustained simultaneous read/write for 3×`LENGTH` cycles (wrap-around): output equals input order, `usedw` constant.
- Assert `rst_n=0` mid-burst at `usedw=5`, asynchronously between edges: all outputs reach reset values immediately. Repeat with `sclr`: cleared at the next edge despite concurrent `wrreq`.
